// File: rtl/glitch_sequencer_if.sv
// rtl/glitch_sequencer_if.sv - control, configuration and glitch-core drive bundle
interface glitch_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int REP_W = 8
);
  logic             arm;
  logic             abort;
  logic             trigger;
  logic [7:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic             glitch_en;
  logic [7:0]       glitch_mode;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_cnt;

  modport master (
    output arm, abort, trigger, cfg_mode, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
    input  glitch_en, glitch_mode, busy, done, pulse_cnt
  );

  modport slave (
    input  arm, abort, trigger, cfg_mode, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
    output glitch_en, glitch_mode, busy, done, pulse_cnt
  );
endinterface

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - trigger-to-pulse-train timing controller for the glitch core
module glitch_sequencer #(
  parameter int CNT_W = 32,
  parameter int REP_W = 8
) (
  input logic               clk_in,
  input logic               rst,
  glitch_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_PULSE,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             trig_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [REP_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]       mode_q, mode_d;
  logic [7:0]       gmode_q, gmode_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_pulse;

  // The trigger is asynchronous: two sync stages plus one history stage for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.trigger;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign trig_edge = s2_q & ~s3_q;

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      width_q <= '0;
      gap_q   <= '0;
      rem_q   <= '0;
      pcnt_q  <= '0;
      mode_q  <= '0;
      gmode_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      gmode_q <= gmode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; every output is computed from the next state so nothing toggles combinationally.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_d     = delay_q;
    width_d     = width_q;
    gap_d       = gap_q;
    rem_d       = rem_q;
    pcnt_d      = pcnt_q;
    mode_d      = mode_q;
    en_d        = en_q;
    done_d      = 1'b0;
    start_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.arm && !bus.abort) begin
          state_d = ST_ARMED;
          pcnt_d  = '0;
          mode_d  = bus.cfg_mode;
          delay_d = bus.cfg_delay;
          width_d = (bus.cfg_width == '0) ? CNT_ONE : bus.cfg_width;
          gap_d   = bus.cfg_gap;
          rem_d   = (bus.cfg_repeat == '0) ? REP_ONE : bus.cfg_repeat;
        end
      end
      ST_ARMED: begin
        if (trig_edge) begin
          if (delay_q == '0) begin
            start_pulse = 1'b1;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_q - CNT_ONE;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) start_pulse = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            // Back-to-back pulses merge into one continuous enable window.
            start_pulse = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = gap_q - CNT_ONE;
            en_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) start_pulse = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // Shared entry actions for every way into PULSE; remaining is always >= 1 here.
    if (start_pulse) begin
      state_d = ST_PULSE;
      en_d    = 1'b1;
      cnt_d   = width_q - CNT_ONE;
      pcnt_d  = pcnt_q + REP_ONE;
      rem_d   = rem_q - REP_ONE;
    end

    // Abort wins over everything, but the pulse count of the cut-short sequence is kept.
    if (bus.abort) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      delay_d = delay_q;
      width_d = width_q;
      gap_d   = gap_q;
      rem_d   = rem_q;
      pcnt_d  = pcnt_q;
      mode_d  = mode_q;
    end

    busy_d  = (state_d != ST_IDLE);
    gmode_d = busy_d ? mode_d : 8'h00;
  end

  assign bus.glitch_en   = en_q;
  assign bus.glitch_mode = gmode_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulse_cnt   = pcnt_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - self-checking bench for glitch_sequencer against a timeline model
module tb_glitch_sequencer;

  logic clk;
  logic rst;

  glitch_sequencer_if #(.CNT_W(32), .REP_W(8)) bus ();

  glitch_sequencer #(.CNT_W(32), .REP_W(8)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cur_rel;

  // Configuration of the sequence currently expected (raw, unclamped values).
  int         m_d, m_w, m_g, m_r;
  logic [7:0] m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s rel=%0d observed=%0h expected=%0h", tag, cur_rel, obs, exp);
    end
  endtask

  // Edge index (relative to k) at which the final pulse falls.
  function automatic int seq_end();
    int wc, rc;
    wc = (m_w == 0) ? 1 : m_w;
    rc = (m_r == 0) ? 1 : m_r;
    return 2 + m_d + (rc - 1) * (wc + m_g) + wc;
  endfunction

  // Expected outputs after edge k+c, derived from the pulse timeline.
  function automatic void model(input int c, output logic en, output logic dn,
                                output logic by, output int pc);
    int wc, rc, per, rise, fin;
    wc  = (m_w == 0) ? 1 : m_w;
    rc  = (m_r == 0) ? 1 : m_r;
    per = wc + m_g;
    en  = 1'b0;
    pc  = 0;
    for (int n = 0; n < rc; n++) begin
      rise = 2 + m_d + n * per;
      if (c >= rise) pc++;
      if (c >= rise && c < rise + wc) en = 1'b1;
    end
    fin = seq_end();
    dn  = (c == fin);
    by  = (c < fin);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_en"},   bus.glitch_en,   0);
    chk({tag, "_mode"}, bus.glitch_mode, 0);
    chk({tag, "_busy"}, bus.busy,        0);
    chk({tag, "_done"}, bus.done,        0);
    chk({tag, "_pcnt"}, bus.pulse_cnt,   0);
  endtask

  task automatic check_cycle(input int c);
    logic en, dn, by;
    int   pc;
    model(c, en, dn, by, pc);
    chk("glitch_en",   bus.glitch_en,   en);
    chk("done",        bus.done,        dn);
    chk("busy",        bus.busy,        by);
    chk("pulse_cnt",   bus.pulse_cnt,   pc);
    chk("glitch_mode", bus.glitch_mode, by ? m_mode : 8'h00);
  endtask

  task automatic arm_cfg(input int d, input int w, input int g, input int r, input logic [7:0] mode);
    m_d = d; m_w = w; m_g = g; m_r = r; m_mode = mode;
    bus.cfg_delay  = d;
    bus.cfg_width  = w;
    bus.cfg_gap    = g;
    bus.cfg_repeat = 8'(r);
    bus.cfg_mode   = mode;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    cur_rel = -1;
    chk("arm_busy", bus.busy,        1);
    chk("arm_en",   bus.glitch_en,   0);
    chk("arm_mode", bus.glitch_mode, mode);
    chk("arm_pcnt", bus.pulse_cnt,   0);
    chk("arm_done", bus.done,        0);
  endtask

  // Low-then-high trigger; the rising level is first sampled at edge k (rel 0).
  task automatic run_trig(input int stop_rel, input int poke_rel);
    bus.trigger = 1'b0;
    repeat (3) begin
      tick();
      cur_rel = -2;
      chk("pre_busy", bus.busy,      1);
      chk("pre_en",   bus.glitch_en, 0);
    end
    bus.trigger = 1'b1;
    for (int c = 0; c <= stop_rel; c++) begin
      tick();
      cur_rel = c;
      check_cycle(c);
      if (c == poke_rel) begin
        bus.arm        = 1'b1;
        bus.cfg_mode   = 8'($urandom);
        bus.cfg_delay  = $urandom_range(0, 3);
        bus.cfg_width  = $urandom_range(5, 9);
        bus.cfg_gap    = $urandom_range(5, 9);
        bus.cfg_repeat = 8'($urandom_range(5, 9));
      end else begin
        bus.arm = 1'b0;
      end
    end
    bus.arm = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.trigger    = 1'b0;
    bus.cfg_mode   = '0;
    bus.cfg_delay  = '0;
    bus.cfg_width  = '0;
    bus.cfg_gap    = '0;
    bus.cfg_repeat = '0;
    cur_rel        = -1;

    // Reset state
    tick();
    tick();
    check_idle_zero("rst");
    rst = 1'b0;
    repeat (4) tick();
    check_idle_zero("post_rst");

    // Basic single pulse
    arm_cfg(5, 3, 0, 1, 8'h08);
    run_trig(seq_end() + 3, -1);

    // Pulse train
    arm_cfg(0, 2, 4, 3, 8'h5A);
    run_trig(seq_end() + 3, -1);

    // Zero gap and zero width merge into one window
    arm_cfg(1, 0, 0, 4, 8'hC3);
    run_trig(seq_end() + 3, -1);

    // Randomized configurations
    for (int i = 0; i < 8; i++) begin
      arm_cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 8'($urandom));
      run_trig(seq_end() + 3, -1);
    end

    // Arm while busy must not disturb the running sequence
    arm_cfg(6, 3, 2, 2, 8'h11);
    run_trig(seq_end() + 3, 4);

    // Trigger already high at arm: stays ARMED until a fresh rising edge
    bus.trigger = 1'b1;
    repeat (4) tick();
    arm_cfg(2, 2, 1, 2, 8'h77);
    repeat (10) begin
      tick();
      cur_rel = -1;
      chk("hold_busy", bus.busy,      1);
      chk("hold_en",   bus.glitch_en, 0);
      chk("hold_pcnt", bus.pulse_cnt, 0);
    end
    run_trig(seq_end() + 3, -1);

    // Abort mid-pulse
    arm_cfg(3, 100, 0, 1, 8'hA5);
    run_trig(2 + 3 + 10, -1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    cur_rel = 2 + 3 + 11;
    chk("abort_en",   bus.glitch_en,   0);
    chk("abort_busy", bus.busy,        0);
    chk("abort_mode", bus.glitch_mode, 0);
    chk("abort_done", bus.done,        0);
    chk("abort_pcnt", bus.pulse_cnt,   1);
    repeat (3) begin
      tick();
      chk("post_abort_done", bus.done,      0);
      chk("post_abort_en",   bus.glitch_en, 0);
      chk("post_abort_busy", bus.busy,      0);
    end

    // Asynchronous reset during DELAY
    arm_cfg(50, 4, 0, 2, 8'h3C);
    run_trig(8, -1);
    #1;
    rst = 1'b1;
    #2;
    cur_rel = -3;
    check_idle_zero("rst_delay");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_idle_zero("rst_delay_rel");

    // Asynchronous reset mid-pulse drops glitch_en before the next edge
    arm_cfg(1, 20, 0, 1, 8'h99);
    run_trig(3 + 5, -1);
    #1;
    rst = 1'b1;
    #2;
    cur_rel = -3;
    check_idle_zero("rst_pulse");
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Normal operation after reset, repeat 0 clamped to 1
    arm_cfg(0, 1, 0, 0, 8'h01);
    run_trig(seq_end() + 3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
